// File: rtl/issue_scoreboard_pkg.sv
// Shared types and sizing for the issue-stage register scoreboard.
// Counter width and register count are set here so every file agrees on them.
package issue_scoreboard_pkg;

    localparam int REG_NUM  = 64;
    localparam int SB_CNT_W = 3;
    localparam int REG_AW   = $clog2(REG_NUM);

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX = '1;

    typedef struct packed {
        logic      valid;
        logic      ren1;
        logic      ren2;
        reg_addr_t raddr1;
        reg_addr_t raddr2;
        logic      wen;
        reg_addr_t waddr;
    } sb_slot_t;

    // Number of enabled ports (0..2) whose address selects register r.
    function automatic logic [1:0] sb_hits(input logic      a_en,
                                           input reg_addr_t a_addr,
                                           input logic      b_en,
                                           input reg_addr_t b_addr,
                                           input reg_addr_t r);
        sb_hits = {1'b0, (a_en && (a_addr == r))} + {1'b0, (b_en && (b_addr == r))};
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue/writeback bundle between the issue logic and the scoreboard.
// The master side drives decoded slots, issue strobes, writebacks and flush.
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    sb_slot_t             inst1;
    sb_slot_t             inst2;
    logic                 inst1_issue;
    logic                 inst2_issue;
    logic [3:0]           wb1_we;
    reg_addr_t            wb1_waddr;
    logic [3:0]           wb2_we;
    reg_addr_t            wb2_waddr;
    logic                 flush;
    logic                 inst1_ready;
    logic                 inst2_ready;
    logic [REG_NUM-1:0]   busy_vec;
    logic                 err_underflow;

    modport master (
        output inst1, inst2, inst1_issue, inst2_issue,
               wb1_we, wb1_waddr, wb2_we, wb2_waddr, flush,
        input  inst1_ready, inst2_ready, busy_vec, err_underflow
    );

    modport slave (
        input  inst1, inst2, inst1_issue, inst2_issue,
               wb1_we, wb1_waddr, wb2_we, wb2_waddr, flush,
        output inst1_ready, inst2_ready, busy_vec, err_underflow
    );

endinterface

// File: rtl/issue_scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Nets up to two increments and two decrements per cycle; clamps at zero.
module issue_scoreboard_counter
    import issue_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       grace,
    input  logic [1:0] inc,
    input  logic [1:0] dec,
    output sb_cnt_t    cnt,
    output logic       busy,
    output logic       underflow
);

    localparam int SUM_W = SB_CNT_W + 2;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] dec_ext;
    logic [SUM_W-1:0] nxt;
    logic             short_fall;

    // Overflow is prevented by the ready logic; saturating here only keeps
    // an illegal issue from wrapping the count back to a small value.
    always_comb begin
        sum        = {2'b00, cnt} + {{SB_CNT_W{1'b0}}, inc};
        dec_ext    = {{SB_CNT_W{1'b0}}, dec};
        short_fall = (sum < dec_ext);
        nxt        = '0;
        if (!short_fall) begin
            nxt = sum - dec_ext;
            if (nxt > {2'b00, SB_CNT_MAX}) begin
                nxt = {2'b00, SB_CNT_MAX};
            end
        end
    end

    assign underflow = short_fall && !flush && !grace;
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= nxt[SB_CNT_W-1:0];
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write counts gating two in-order issue slots.
// Readiness uses registered counts only, so a writeback frees its register one cycle later.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    issue_scoreboard_if.slave   sb
);

    sb_cnt_t            cnt [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] uf;
    logic               grace;
    logic               err;

    logic               src1_ok;
    logic               src2_ok;
    logic               full1;
    logic               full2;
    logic               raw12;
    logic               waw_full;
    logic               ready1;
    logic               ready2;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;
    assign uf[0]   = 1'b0;

    // Register 0 is hardwired and never tracked, so counters start at 1.
    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        logic [1:0] inc;
        logic [1:0] dec;

        assign inc = sb_hits(sb.inst1_issue && sb.inst1.wen, sb.inst1.waddr,
                             sb.inst2_issue && sb.inst2.wen, sb.inst2.waddr,
                             reg_addr_t'(r));
        assign dec = sb_hits(|sb.wb1_we, sb.wb1_waddr,
                             |sb.wb2_we, sb.wb2_waddr,
                             reg_addr_t'(r));

        issue_scoreboard_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .flush     (sb.flush),
            .grace     (grace),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt[r]),
            .busy      (busy[r]),
            .underflow (uf[r])
        );
    end

    always_comb begin
        src1_ok = !(sb.inst1.ren1 && busy[sb.inst1.raddr1]) &&
                  !(sb.inst1.ren2 && busy[sb.inst1.raddr2]);
        src2_ok = !(sb.inst2.ren1 && busy[sb.inst2.raddr1]) &&
                  !(sb.inst2.ren2 && busy[sb.inst2.raddr2]);

        full1 = sb.inst1.wen && (sb.inst1.waddr != '0) && (cnt[sb.inst1.waddr] == SB_CNT_MAX);
        full2 = sb.inst2.wen && (sb.inst2.waddr != '0) && (cnt[sb.inst2.waddr] == SB_CNT_MAX);

        raw12 = sb.inst1.wen && (sb.inst1.waddr != '0) &&
                ((sb.inst2.ren1 && (sb.inst2.raddr1 == sb.inst1.waddr)) ||
                 (sb.inst2.ren2 && (sb.inst2.raddr2 == sb.inst1.waddr)));

        // Both slots writing the same register need room for two more writes.
        waw_full = sb.inst1.wen && sb.inst2.wen && (sb.inst1.waddr == sb.inst2.waddr) &&
                   (sb.inst1.waddr != '0) &&
                   (cnt[sb.inst1.waddr] > (SB_CNT_MAX - sb_cnt_t'(2)));

        ready1 = sb.inst1.valid && src1_ok && !full1;
        ready2 = sb.inst2.valid && sb.inst1_issue && src2_ok && !full2 && !raw12 && !waw_full;
    end

    assign sb.inst1_ready   = ready1;
    assign sb.inst2_ready   = ready2;
    assign sb.busy_vec      = busy;
    assign sb.err_underflow = err;

    // Completions of squashed ops may still arrive the cycle after a flush;
    // grace suppresses the error for exactly that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grace <= 1'b0;
            err   <= 1'b0;
        end else begin
            grace <= sb.flush;
            if (|uf) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: directed scenarios then randomized traffic, checked
// against a count-per-register reference model.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int   m_cnt [REG_NUM];
    bit   m_err;
    bit   m_grace;

    issue_scoreboard_if sb_if ();

    issue_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic sb_slot_t mkSlot(input bit v, input bit r1, input int a1,
                                        input bit r2, input int a2, input bit w, input int wa);
        sb_slot_t s;
        s.valid  = v;
        s.ren1   = r1;
        s.raddr1 = reg_addr_t'(a1);
        s.ren2   = r2;
        s.raddr2 = reg_addr_t'(a2);
        s.wen    = w;
        s.waddr  = reg_addr_t'(wa);
        return s;
    endfunction

    task automatic clearInputs();
        sb_if.inst1       = '0;
        sb_if.inst2       = '0;
        sb_if.inst1_issue = 1'b0;
        sb_if.inst2_issue = 1'b0;
        sb_if.wb1_we      = '0;
        sb_if.wb1_waddr   = '0;
        sb_if.wb2_we      = '0;
        sb_if.wb2_waddr   = '0;
        sb_if.flush       = 1'b0;
    endtask

    function automatic bit mBusy(input int a);
        return (a != 0) && (m_cnt[a] != 0);
    endfunction

    function automatic bit mSrcOk(input sb_slot_t s);
        return !(s.ren1 && mBusy(int'(s.raddr1))) && !(s.ren2 && mBusy(int'(s.raddr2)));
    endfunction

    function automatic bit mFull(input sb_slot_t s);
        return s.wen && (s.waddr != 0) && (m_cnt[int'(s.waddr)] == 7);
    endfunction

    function automatic bit mReady1();
        return sb_if.inst1.valid && mSrcOk(sb_if.inst1) && !mFull(sb_if.inst1);
    endfunction

    function automatic bit mReady2();
        sb_slot_t a;
        sb_slot_t b;
        bit raw;
        bit pair;
        a    = sb_if.inst1;
        b    = sb_if.inst2;
        raw  = a.wen && (a.waddr != 0) &&
               ((b.ren1 && b.raddr1 == a.waddr) || (b.ren2 && b.raddr2 == a.waddr));
        pair = a.wen && b.wen && (a.waddr == b.waddr) && (a.waddr != 0) &&
               (m_cnt[int'(a.waddr)] > 5);
        return b.valid && sb_if.inst1_issue && mSrcOk(b) && !mFull(b) && !raw && !pair;
    endfunction

    function automatic logic [63:0] mBusyVec();
        logic [63:0] v;
        v = '0;
        for (int r = 1; r < REG_NUM; r++) v[r] = (m_cnt[r] != 0);
        return v;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < REG_NUM; r++) m_cnt[r] = 0;
        m_err   = 1'b0;
        m_grace = 1'b0;
    endtask

    task automatic modelUpdate();
        int d [REG_NUM];
        int v;
        if (sb_if.flush) begin
            for (int r = 0; r < REG_NUM; r++) m_cnt[r] = 0;
            m_grace = 1'b1;
        end else begin
            for (int r = 0; r < REG_NUM; r++) d[r] = 0;
            if (sb_if.inst1_issue && sb_if.inst1.wen) d[int'(sb_if.inst1.waddr)]++;
            if (sb_if.inst2_issue && sb_if.inst2.wen) d[int'(sb_if.inst2.waddr)]++;
            if (sb_if.wb1_we != 0) d[int'(sb_if.wb1_waddr)]--;
            if (sb_if.wb2_we != 0) d[int'(sb_if.wb2_waddr)]--;
            for (int r = 1; r < REG_NUM; r++) begin
                v = m_cnt[r] + d[r];
                if (v < 0) begin
                    v = 0;
                    if (!m_grace) m_err = 1'b1;
                end
                if (v > 7) v = 7;
                m_cnt[r] = v;
            end
            m_grace = 1'b0;
        end
    endtask

    // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic runCycle();
        #1;
        checkOutput("inst1_ready", sb_if.inst1_ready, mReady1());
        checkOutput("inst2_ready", sb_if.inst2_ready, mReady2());
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput("busy_vec", sb_if.busy_vec, mBusyVec());
        checkOutput("err_underflow", sb_if.err_underflow, m_err);
    endtask

    task automatic applyStimulus();
        int wa;
        clearInputs();
        sb_if.inst1 = mkSlot($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                             $urandom_range(0, 1), $urandom_range(0, 7),
                             $urandom_range(0, 1), $urandom_range(0, 7));
        sb_if.inst2 = mkSlot($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                             $urandom_range(0, 1), $urandom_range(0, 7),
                             $urandom_range(0, 1), $urandom_range(0, 7));
        sb_if.inst1_issue = mReady1() && ($urandom_range(0, 3) != 0);
        sb_if.inst2_issue = mReady2() && ($urandom_range(0, 3) != 0);
        for (int p = 0; p < 2; p++) begin
            wa = 0;
            if ($urandom_range(0, 15) == 0) begin
                wa = $urandom_range(0, 7);
            end else begin
                for (int t = 0; t < 8; t++) begin
                    int c;
                    c = $urandom_range(1, 7);
                    if (m_cnt[c] != 0) begin
                        wa = c;
                        break;
                    end
                end
            end
            if (p == 0) begin
                sb_if.wb1_waddr = reg_addr_t'(wa);
                sb_if.wb1_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end else begin
                sb_if.wb2_waddr = reg_addr_t'(wa);
                sb_if.wb2_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
        end
        sb_if.flush = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", sb_if.busy_vec, 64'h0);
        checkOutput("reset_err", sb_if.err_underflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Writeback does not bypass: r5 becomes readable the cycle after wb.
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 5);
        sb_if.inst1_issue = 1'b1;
        runCycle();
        for (int c = 1; c <= 3; c++) begin
            clearInputs();
            sb_if.inst1 = mkSlot(1, 1, 5, 0, 0, 0, 0);
            sb_if.inst2 = mkSlot(1, 1, 5, 0, 0, 0, 0);
            if (c == 3) begin
                sb_if.wb1_we    = 4'b0001;
                sb_if.wb1_waddr = reg_addr_t'(5);
            end
            #1;
            checkOutput("r5_wait_ready1", sb_if.inst1_ready, 1'b0);
            checkOutput("r5_wait_ready2", sb_if.inst2_ready, 1'b0);
            runCycle();
        end
        clearInputs();
        sb_if.inst1 = mkSlot(1, 1, 5, 0, 0, 0, 0);
        sb_if.inst2 = mkSlot(1, 1, 5, 0, 0, 0, 0);
        sb_if.inst1_issue = 1'b1;
        #1;
        checkOutput("r5_free_ready1", sb_if.inst1_ready, 1'b1);
        checkOutput("r5_free_ready2", sb_if.inst2_ready, 1'b1);
        runCycle();

        // Same-cycle RAW between slots, and the r0 exemption.
        clearInputs();
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 7);
        sb_if.inst2 = mkSlot(1, 1, 7, 0, 0, 0, 0);
        sb_if.inst1_issue = 1'b1;
        #1;
        checkOutput("raw_r7_ready2", sb_if.inst2_ready, 1'b0);
        runCycle();
        clearInputs();
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 0);
        sb_if.inst2 = mkSlot(1, 1, 0, 0, 0, 0, 0);
        sb_if.inst1_issue = 1'b1;
        #1;
        checkOutput("raw_r0_ready2", sb_if.inst2_ready, 1'b1);
        runCycle();
        clearInputs();
        sb_if.wb1_we    = 4'b1000;
        sb_if.wb1_waddr = reg_addr_t'(7);
        runCycle();

        // Saturate r9 at 7 outstanding writes.
        for (int i = 0; i < 7; i++) begin
            clearInputs();
            sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 9);
            sb_if.inst1_issue = 1'b1;
            runCycle();
        end
        clearInputs();
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 9);
        #1;
        checkOutput("r9_full_ready1", sb_if.inst1_ready, 1'b0);
        runCycle();
        sb_if.inst1_issue = 1'b1;
        sb_if.wb1_we      = 4'b0010;
        sb_if.wb1_waddr   = reg_addr_t'(9);
        runCycle();
        clearInputs();
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 9);
        #1;
        checkOutput("r9_net_ready1", sb_if.inst1_ready, 1'b0);
        checkOutput("r9_net_busy", sb_if.busy_vec[9], 1'b1);
        runCycle();

        // Flush clears everything; a stale completion right after is forgiven.
        clearInputs();
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 4);
        sb_if.inst2 = mkSlot(1, 0, 0, 0, 0, 1, 6);
        sb_if.inst1_issue = 1'b1;
        sb_if.inst2_issue = 1'b1;
        #1;
        checkOutput("flush_setup_ready2", sb_if.inst2_ready, 1'b1);
        runCycle();
        clearInputs();
        sb_if.flush = 1'b1;
        runCycle();
        checkOutput("flush_busy", sb_if.busy_vec, 64'h0);
        clearInputs();
        sb_if.wb1_we    = 4'b0001;
        sb_if.wb1_waddr = reg_addr_t'(4);
        runCycle();
        checkOutput("flush_grace_err", sb_if.err_underflow, 1'b0);

        // Double writeback on a count of 1 underflows and sticks.
        clearInputs();
        sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 3);
        sb_if.inst1_issue = 1'b1;
        runCycle();
        clearInputs();
        sb_if.wb1_we    = 4'b0001;
        sb_if.wb1_waddr = reg_addr_t'(3);
        sb_if.wb2_we    = 4'b1000;
        sb_if.wb2_waddr = reg_addr_t'(3);
        runCycle();
        checkOutput("uf_err", sb_if.err_underflow, 1'b1);
        checkOutput("uf_busy3", sb_if.busy_vec[3], 1'b0);
        clearInputs();
        runCycle();
        checkOutput("uf_sticky", sb_if.err_underflow, 1'b1);

        // Asynchronous reset mid-operation with three writes pending on r12.
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            sb_if.inst1 = mkSlot(1, 0, 0, 0, 0, 1, 12);
            sb_if.inst1_issue = 1'b1;
            runCycle();
        end
        clearInputs();
        checkOutput("pre_rst_busy12", sb_if.busy_vec[12], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", sb_if.busy_vec, 64'h0);
        checkOutput("async_rst_err", sb_if.err_underflow, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            runCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
